mmio_console: RTL

// - Memory-mapped output peripheral on the core data bus, in parallel with memory.
// - Captures core stores to the I/O window and queues them in a FIFO.
// - Drains the FIFO to a downstream sink over valid/ready.
// - Exposes status and drop counter for core reads; raises sticky halt on a store to HALT_ADDR.

---
 rtl/mmio_console.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mmio_console.sv
// Memory-mapped console: queues TXDATA stores in a FIFO drained over valid/ready,
// exposes STATUS/DROPCNT reads and a sticky halt. Drop counter enabled by MMIO_CONSOLE_DROPCNT_EN.
module mmio_console #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h800,
    parameter logic [31:0] HALT_ADDR  = 32'hFFC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic [3:0]  byte_enable,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        rsel,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    output logic        halt
);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] count;
    logic        full;
    logic        empty;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        in_window;
    logic [31:0] masked;
    logic [31:0] status_word;
    logic [31:0] dropcnt_value;
    logic [31:0] read_value;

    assign count = wptr - rptr;
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // Handshake: the head word transfers on a rising edge where tx_valid & tx_ready;
    // tx_data holds steady while tx_valid is high and the sink stalls.
    assign tx_valid = ~empty;
    assign tx_data  = empty ? '0 : mem[rptr[AW-1:0]];
    assign pop      = tx_valid & tx_ready;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_req = we & (address == BASE_ADDR);
    assign push     = push_req & ~halt & (~full | pop);
    assign masked   = data_in & {{8{byte_enable[3]}}, {8{byte_enable[2]}},
                                 {8{byte_enable[1]}}, {8{byte_enable[0]}}};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= masked;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            halt <= 1'b0;
        end else if (we && (address == HALT_ADDR)) begin
            halt <= 1'b1;
        end
    end

`ifdef MMIO_CONSOLE_DROPCNT_EN
    logic [31:0] dropcnt;
    logic        drop;

    assign drop = push_req & ~push;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dropcnt <= '0;
        end else if (drop && (dropcnt != '1)) begin
            dropcnt <= dropcnt + 32'd1;
        end
    end

    assign dropcnt_value = dropcnt;
`else
    assign dropcnt_value = '0;
`endif

    assign status_word = {halt, 15'b0, 14'(count), full, empty};
    assign in_window   = (address >= BASE_ADDR) && (address <= HALT_ADDR);

    always_comb begin
        read_value = '0;
        if (address == BASE_ADDR + 32'd4) begin
            read_value = status_word;
        end else if (address == BASE_ADDR + 32'd8) begin
            read_value = dropcnt_value;
        end
    end

    // Read data is registered so it lines up with the memory's one-cycle load latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsel  <= 1'b0;
            rdata <= '0;
        end else if (!we && in_window) begin
            rsel  <= 1'b1;
            rdata <= read_value;
        end else begin
            rsel  <= 1'b0;
            rdata <= '0;
        end
    end

endmodule
